// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: control stage in front of the stack pointer.
// Accepts PUSH/POP/LOAD_SP/READ_SP over valid/ready, drives pointer strobes
// (I_SP, D_SP, E_SP) and the matching memory strobes, returns popped data,
// and keeps a shadow depth count.
// Optional macro STACK_GUARD_EN: reject overflow/underflow/out-of-range loads
// and flag them on stk_err; when undefined, ops always execute and depth wraps.
module stack_op_sequencer #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int STACK_LIMIT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] op_data,
    output logic              I_SP,
    output logic              D_SP,
    output logic              E_SP,
    output logic [ADDR_W-1:0] sp_load_bus,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [ADDR_W:0]   depth,
    output logic              stk_err
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT} state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_wdata;
    logic [ADDR_W-1:0]   r_load;
    logic [DATA_W-1:0]   r_pop_data;
    logic [ADDR_W:0]     r_depth;
    logic                w_accept;
    logic                w_rej;
    logic                w_exec_ok;

    // Requests are only taken in IDLE, and never while reset is held.
    assign op_ready    = (r_state == S_IDLE) && !RST;
    assign w_accept    = op_valid && op_ready;
    assign w_exec_ok   = (r_state == S_EXEC) && !w_rej;
    assign mem_wdata   = r_wdata;
    assign sp_load_bus = r_load;
    assign depth       = r_depth;
    // The RAM word only arrives in CAPT, so forward it that cycle; hold it afterwards.
    assign pop_data    = (r_state == S_CAPT) ? mem_rdata : r_pop_data;

`ifdef STACK_GUARD_EN
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(STACK_LIMIT);
    logic r_load_oor;

    // Range-check the LOAD_SP operand at accept so the full op_data need not be held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_load_oor <= 1'b0;
        else if (w_accept)
            r_load_oor <= 32'(op_data) > 32'(STACK_LIMIT);
    end

    // Guarded ops go through EXEC without touching pointer or memory.
    always_comb begin
        w_rej = 1'b0;
        case (r_op)
            OP_PUSH: w_rej = (r_depth == LIMIT);
            OP_POP:  w_rej = (r_depth == '0);
            OP_LOAD: w_rej = r_load_oor;
            default: w_rej = 1'b0;
        endcase
    end
`else
    assign w_rej = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Latch the accepted request; write data and load value are kept per op.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_op    <= OP_PUSH;
            r_wdata <= '0;
            r_load  <= '0;
        end else if (w_accept) begin
            r_op <= op_code;
            if (op_code == OP_PUSH)
                r_wdata <= op_data;
            if (op_code == OP_LOAD)
                r_load <= op_data[ADDR_W-1:0];
        end
    end

    // Shadow depth follows executed ops; MSB stays 0 so it wraps mod 2**ADDR_W.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_depth <= '0;
        else if (w_exec_ok) begin
            case (r_op)
                OP_PUSH: r_depth <= {1'b0, r_depth[ADDR_W-1:0] + ADDR_W'(1)};
                OP_POP:  r_depth <= {1'b0, r_depth[ADDR_W-1:0] - ADDR_W'(1)};
                OP_LOAD: r_depth <= {1'b0, r_load};
                default: r_depth <= r_depth;
            endcase
        end
    end

    // Capture the popped word at the end of CAPT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_pop_data <= '0;
        else if (r_state == S_CAPT)
            r_pop_data <= mem_rdata;
    end

    // Next state and strobes: strobes only in EXEC, pop_valid only in CAPT.
    always_comb begin
        w_next    = r_state;
        I_SP      = 1'b0;
        D_SP      = 1'b0;
        E_SP      = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        pop_valid = 1'b0;
        stk_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_IDLE;
                if (w_rej)
                    stk_err = 1'b1;
                else begin
                    case (r_op)
                        OP_PUSH: begin
                            mem_we = 1'b1;
                            I_SP   = 1'b1;
                        end
                        OP_POP: begin
                            D_SP   = 1'b1;
                            mem_re = 1'b1;
                            w_next = S_CAPT;
                        end
                        OP_LOAD: begin
                            I_SP = 1'b1;
                            D_SP = 1'b1;
                        end
                        default: E_SP = 1'b1;
                    endcase
                end
            end
            S_CAPT: begin
                pop_valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
